// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus pacing stage in front of a UART transmitter
// that has no ready output and restarts on every enable. Bytes are queued at
// any rate and released one per FRAME_CYCLES as a one-cycle enable pulse.
//
// Optional build macro UART_TX_FEEDER_LEVEL_EN adds two outputs:
//   fifo_level [DEPTH_LOG2:0] : registered write-minus-read pointer difference
//   tx_count   [15:0]         : count of enable pulses issued, wraps at 65535
module uart_tx_feeder #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int UART_BAUD  = 115200,
  parameter int GAP_BITS   = 1,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  overflow,
  output logic                  busy,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_enable
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]           tx_count
`endif
);

  // Clocks per line bit and enable-to-enable spacing (FRAME_CYCLES must be >= 4).
  localparam int BIT_CYCLES   = CLOCK_FREQ / UART_BAUD + 1;
  localparam int FRAME_CYCLES = BIT_CYCLES * (11 + GAP_BITS);
  localparam int DEPTH        = 1 << DEPTH_LOG2;
  localparam int PTR_W        = DEPTH_LOG2 + 1;

  // Pulse is issued on the edge leaving PULSE; the next pulse needs one WAIT
  // expiry edge, one IDLE pop edge and one PULSE edge, so WAIT counts F-3 down.
  localparam logic [31:0] TIMER_LOAD = 32'(FRAME_CYCLES - 3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        timer_q;
  logic [7:0]         tx_data_q;
  logic               tx_enable_q;

  logic [7:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_d;
  logic               full_q;
  logic               empty_q;
  logic               full_d;
  logic               empty_d;
  logic               overflow_q;

  logic               wr_accept;
  logic               pop;

  // A write is taken only when not full; a pop never frees space for a
  // write in the same cycle, so a write while full is always dropped.
  assign wr_accept = wr_en & ~full_q;
  assign pop       = (state_q == S_IDLE) & ~empty_q;

  // Next pointer values and the flags derived from them.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
              (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]);
  end

  // FIFO storage: plain array, no reset, so it can map onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  // Pointers, registered full/empty flags and the sticky overflow flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      if (wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Pacing FSM: pop in IDLE, one-cycle enable from PULSE, count down in WAIT.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      tx_data_q   <= 8'h00;
      tx_enable_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_enable_q <= 1'b0;
          timer_q     <= '0;
          if (!empty_q) begin
            tx_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            state_q   <= S_PULSE;
          end
        end
        S_PULSE: begin
          tx_enable_q <= 1'b1;
          timer_q     <= TIMER_LOAD;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          tx_enable_q <= 1'b0;
          if (timer_q == 32'd0) begin
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        default: begin
          tx_enable_q <= 1'b0;
          timer_q     <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_full      = full_q;
  assign fifo_empty     = empty_q;
  assign overflow       = overflow_q;
  assign uart_tx_data   = tx_data_q;
  assign uart_tx_enable = tx_enable_q;
  assign busy           = (state_q != S_IDLE) | ~empty_q;

`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [PTR_W-1:0] level_q;
  logic [15:0]      tx_count_q;

  // Occupancy tracks the post-edge pointers; the counter steps with each pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      level_q    <= '0;
      tx_count_q <= 16'd0;
    end else begin
      level_q <= wr_ptr_d - rd_ptr_d;
      if (state_q == S_PULSE) begin
        tx_count_q <= tx_count_q + 16'd1;
      end
    end
  end

  assign fifo_level = level_q;
  assign tx_count   = tx_count_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder. A reduced clock/baud keeps the run short:
// 1 MHz / 62.5 kbaud -> 17 clocks per bit, 17 * (11 + 1) = 204 clocks per frame.
module tb_uart_tx_feeder;

  localparam int CF    = 1_000_000;
  localparam int BAUD  = 62_500;
  localparam int GAP   = 1;
  localparam int DL2   = 4;
  localparam int BIT   = 17;
  localparam int FRAME = 204;

  logic       clk_in  = 1'b0;
  logic       rst_in  = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en   = 1'b0;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic       busy;
  logic [7:0] uart_tx_data;
  logic       uart_tx_enable;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [DL2:0] fifo_level;
  logic [15:0]  tx_count;
`endif

  uart_tx_feeder #(
    .CLOCK_FREQ (CF),
    .UART_BAUD  (BAUD),
    .GAP_BITS   (GAP),
    .DEPTH_LOG2 (DL2)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .overflow       (overflow),
    .busy           (busy),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_enable (uart_tx_enable)
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    .fifo_level     (fifo_level),
    .tx_count       (tx_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Edge counter: at negedge following edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Pulse log: one line per enable pulse.
  int         pulse_cyc[$];
  logic [7:0] pulse_dat[$];
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [15:0] pulse_cnt[$];
`endif
  always @(negedge clk_in) begin
    if (uart_tx_enable === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(uart_tx_data);
`ifdef UART_TX_FEEDER_LEVEL_EN
      pulse_cnt.push_back(tx_count);
`endif
      $display("tx pulse %0d: data=%02h edge=%0d", pulse_cyc.size(), uart_tx_data, cyc);
    end
  end

  // Transmitter model: start, 8 data LSB first, 2 stop bits; counts restarts
  // that arrive while a frame is still on the line.
  logic        tx_active = 1'b0;
  logic [10:0] tx_sh     = '1;
  int          tx_tc     = 0;
  int          tx_bit    = 0;
  int          restarts  = 0;
  logic        tx_line;
  assign tx_line = tx_active ? tx_sh[0] : 1'b1;

  always @(posedge clk_in) begin
    if (uart_tx_enable === 1'b1) begin
      if (tx_active) restarts <= restarts + 1;
      tx_sh     <= {2'b11, uart_tx_data, 1'b0};
      tx_active <= 1'b1;
      tx_tc     <= 0;
      tx_bit    <= 0;
    end else if (tx_active) begin
      if (tx_tc == BIT - 1) begin
        tx_tc  <= 0;
        tx_sh  <= {1'b1, tx_sh[10:1]};
        tx_bit <= tx_bit + 1;
        if (tx_bit == 10) tx_active <= 1'b0;
      end else begin
        tx_tc <= tx_tc + 1;
      end
    end
  end

  // Line receiver: samples each data bit mid-period and queues the byte.
  logic       rx_busy = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_sh   = 8'h00;
  logic [7:0] rx_q[$];

  always @(posedge clk_in) begin
    if (!rx_busy) begin
      if (!tx_line) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == BIT / 2 + 9 * BIT) begin
        rx_q.push_back(rx_sh);
        rx_busy <= 1'b0;
      end else if (rx_cnt > BIT / 2 && ((rx_cnt - BIT / 2) % BIT) == 0) begin
        rx_sh <= {tx_line, rx_sh[7:1]};
      end
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int t;
    t = 0;
    while (pulse_cyc.size() < n && t < budget) begin
      step();
      t++;
    end
    check("pulse_count", pulse_cyc.size(), n);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"},   uart_tx_data,   8'h00);
    check({tag, "_enable"}, uart_tx_enable, 1'b0);
    check({tag, "_empty"},  fifo_empty,     1'b1);
    check({tag, "_full"},   fifo_full,      1'b0);
    check({tag, "_ovf"},    overflow,       1'b0);
    check({tag, "_busy"},   busy,           1'b0);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check({tag, "_level"},  fifo_level,     0);
    check({tag, "_count"},  tx_count,       16'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p;
    int base;

    // Reset state
    #2 rst_in = 1'b1;
    step();
    step();
    check_reset("rst");
    rst_in = 1'b0;
    step();
    step();

    // T1: single byte, 2-cycle latency, one-cycle pulse, busy drops by FRAME
    n = cyc + 1;
    put(8'h55);
    wr_en = 1'b0;
    wait_pulses(1, 40);
    p = pulse_cyc[0];
    check("t1_latency", pulse_cyc[0] - n, 2);
    check("t1_data", pulse_dat[0], 8'h55);
    wait_until(p + 1);
    check("t1_en_width", uart_tx_enable, 1'b0);
    check("t1_data_hold", uart_tx_data, 8'h55);
    wait_until(p + FRAME - 3);
    check("t1_busy_wait", busy, 1'b1);
    wait_until(p + FRAME);
    check("t1_busy_done", busy, 1'b0);
    check("t1_one_pulse", pulse_cyc.size(), 1);

    // T2: three back-to-back bytes, FRAME spacing, line decodes "ABC"
    base = pulse_cyc.size();
    rx_q.delete();
    n = cyc + 1;
    put(8'h41);
    put(8'h42);
    put(8'h43);
    wr_en = 1'b0;
    wait_pulses(base + 3, 3 * FRAME + 40);
    check("t2_latency", pulse_cyc[base] - n, 2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t2_data%0d", k), pulse_dat[base + k], 8'h41 + 8'(k));
      if (k > 0) check($sformatf("t2_gap%0d", k), pulse_cyc[base + k] - pulse_cyc[base + k - 1], FRAME);
    end
    wait_until(pulse_cyc[base + 2] + FRAME);
    check("t2_rx_count", rx_q.size(), 3);
    check("t2_rx0", rx_q[0], 8'h41);
    check("t2_rx1", rx_q[1], 8'h42);
    check("t2_rx2", rx_q[2], 8'h43);

    // T3: 17 consecutive writes fill the FIFO, an 18th overflows
    base = pulse_cyc.size();
    n = cyc + 1;
    for (int i = 0; i < 17; i++) begin
      put(8'h10 + 8'(i));
      if (i == 15) check("t3_full_at15", fifo_full, 1'b0);
    end
    check("t3_full", fifo_full, 1'b1);
    check("t3_ovf_before", overflow, 1'b0);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check("t3_level16", fifo_level, 16);
`endif
    put(8'hEE);
    wr_en = 1'b0;
    check("t3_ovf", overflow, 1'b1);
    check("t3_full_after", fifo_full, 1'b1);
    wait_pulses(base + 17, 17 * FRAME + 40);
    check("t3_latency", pulse_cyc[base] - n, 2);
    for (int k = 0; k < 17; k++) begin
      check($sformatf("t3_data%0d", k), pulse_dat[base + k], 8'h10 + 8'(k));
      if (k > 0) check($sformatf("t3_gap%0d", k), pulse_cyc[base + k] - pulse_cyc[base + k - 1], FRAME);
    end

    // T4: write during WAIT into empty FIFO is held back to FRAME spacing
    p = pulse_cyc[base + 16];
    wait_until(p + 50);
    put(8'h77);
    wr_en = 1'b0;
    wait_pulses(base + 18, FRAME);
    check("t4_gap", pulse_cyc[base + 17] - p, FRAME);
    check("t4_data", pulse_dat[base + 17], 8'h77);
    check("t4_ovf_sticky", overflow, 1'b1);

    // T5: asynchronous reset mid-WAIT with 5 bytes queued
    p = pulse_cyc[base + 17];
    wait_until(p + 10);
    for (int i = 0; i < 5; i++) put(8'hA0 + 8'(i));
    wr_en = 1'b0;
    wait_until(p + 30);
    check("t5_queued", fifo_empty, 1'b0);
    check("t5_busy", busy, 1'b1);
    #2 rst_in = 1'b1;
    #1;
    check_reset("t5_async");
    step();
    step();
    rst_in = 1'b0;
    base = pulse_cyc.size();
    repeat (2 * FRAME) step();
    check("t5_quiet", pulse_cyc.size(), base);

    n = cyc + 1;
    put(8'h99);
    put(8'h9A);
    put(8'h9B);
    put(8'h9C);
    wr_en = 1'b0;
`ifdef UART_TX_FEEDER_LEVEL_EN
    check("t5_level3", fifo_level, 3);
    check("t5_count1", tx_count, 16'd1);
`endif
    wait_pulses(base + 4, 4 * FRAME);
    check("t5_latency", pulse_cyc[base] - n, 2);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_data%0d", k), pulse_dat[base + k], 8'h99 + 8'(k));
      if (k > 0) check($sformatf("t5_gap%0d", k), pulse_cyc[base + k] - pulse_cyc[base + k - 1], FRAME);
`ifdef UART_TX_FEEDER_LEVEL_EN
      check($sformatf("t5_txcount%0d", k), pulse_cnt[base + k], 16'(k + 1));
`endif
    end
    wait_until(pulse_cyc[base + 3] + FRAME);
    check("end_busy", busy, 1'b0);
    check("end_empty", fifo_empty, 1'b1);
    check("end_restarts", restarts, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
